// File: rtl/drive_pkg.sv
// Shared drive-mode encodings for the car controllers plus arbiter/turn-gate state types.
package drive_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_SEMI   = 2'd2,
    MODE_AUTO   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    TG_READY     = 2'd0,
    TG_WAIT_RISE = 2'd1,
    TG_WAIT_FALL = 2'd2,
    TG_GUARD     = 2'd3
  } gate_state_e;

  // Cycles after a pulse within which the car must acknowledge the turn.
  localparam int unsigned TURN_RISE_TIMEOUT = 4;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/turn_gate.sv
// Single-turn-in-flight filter: priority select, one-cycle pulse, wait for turn completion, guard gap.
module turn_gate
  import drive_pkg::*;
#(
  parameter int unsigned TURN_GUARD = 10,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       is_turning,
  output logic       turn_left,
  output logic       turn_right,
  output logic       turn_back,
  output logic       busy
);

  localparam int unsigned RISE_W = $clog2(TURN_RISE_TIMEOUT);
  localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(TURN_RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(TURN_GUARD);

  gate_state_e       phase, phase_d;
  logic [RISE_W-1:0] rise_cnt, rise_cnt_d;
  logic [CNT_W-1:0]  guard_cnt, guard_cnt_d;
  logic              left_d, right_d, back_d, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= TG_READY;
      rise_cnt   <= '0;
      guard_cnt  <= '0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      turn_back  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      phase      <= phase_d;
      rise_cnt   <= rise_cnt_d;
      guard_cnt  <= guard_cnt_d;
      turn_left  <= left_d;
      turn_right <= right_d;
      turn_back  <= back_d;
      busy       <= busy_d;
    end
  end

  // Back beats left beats right; losers in the same cycle are dropped.
  always_comb begin
    phase_d     = phase;
    rise_cnt_d  = rise_cnt;
    guard_cnt_d = guard_cnt;
    left_d      = 1'b0;
    right_d     = 1'b0;
    back_d      = 1'b0;
    case (phase)
      TG_READY: begin
        if (!is_turning && (req != 3'b000)) begin
          if (req[2])      back_d  = 1'b1;
          else if (req[1]) left_d  = 1'b1;
          else             right_d = 1'b1;
          phase_d    = TG_WAIT_RISE;
          rise_cnt_d = '0;
        end
      end
      TG_WAIT_RISE: begin
        if (is_turning) begin
          phase_d = TG_WAIT_FALL;
        end else if (rise_cnt >= RISE_LAST) begin
          // Car never acknowledged; release anyway after the guard gap.
          phase_d     = TG_GUARD;
          guard_cnt_d = GUARD_LOAD;
        end else begin
          rise_cnt_d = rise_cnt + RISE_W'(1);
        end
      end
      TG_WAIT_FALL: begin
        if (!is_turning) begin
          phase_d     = TG_GUARD;
          guard_cnt_d = GUARD_LOAD;
        end
      end
      TG_GUARD: begin
        if (guard_cnt <= CNT_W'(1)) begin
          phase_d     = TG_READY;
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt - CNT_W'(1);
        end
      end
      default: phase_d = TG_READY;
    endcase
    busy_d = (phase_d != TG_READY);
  end

endmodule

// File: rtl/drive_mode_arbiter.sv
// Grants the car's motion/turn interface to manual, semi or auto control with stop-drain-settle handover.
module drive_mode_arbiter
  import drive_pkg::*;
#(
  parameter int unsigned SETTLE     = 50,
  parameter int unsigned TURN_GUARD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_req,
  input  logic       is_turning,
  input  logic       man_fwd,
  input  logic       man_bwd,
  input  logic       man_left,
  input  logic       man_right,
  input  logic       semi_fwd,
  input  logic       semi_tl,
  input  logic       semi_tr,
  input  logic       semi_tb,
  input  logic       auto_fwd,
  input  logic       auto_tl,
  input  logic       auto_tr,
  input  logic       auto_tb,
  output logic       move_forward,
  output logic       move_backward,
  output logic       turn_left,
  output logic       turn_right,
  output logic       turn_back,
  output logic       semi_enable,
  output logic       auto_enable,
  output logic [1:0] active_mode,
  output logic       switching
);

  localparam int unsigned CNT_W = cnt_width(SETTLE, TURN_GUARD);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  arb_state_e       state, state_d;
  mode_e            target, target_d;
  mode_e            active_q, active_d;
  mode_e            req_mode;
  logic [CNT_W-1:0] settle_cnt, settle_cnt_d;
  logic             man_left_q, man_right_q;
  logic             fwd_d, bwd_d, semi_en_d, auto_en_d, switching_d;
  logic             stay_active;
  logic [2:0]       turn_req;
  logic             gate_busy;

  assign req_mode    = mode_e'(mode_req);
  assign active_mode = active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      target        <= MODE_OFF;
      active_q      <= MODE_OFF;
      settle_cnt    <= '0;
      man_left_q    <= 1'b0;
      man_right_q   <= 1'b0;
      move_forward  <= 1'b0;
      move_backward <= 1'b0;
      semi_enable   <= 1'b0;
      auto_enable   <= 1'b0;
      switching     <= 1'b0;
    end else begin
      state         <= state_d;
      target        <= target_d;
      active_q      <= active_d;
      settle_cnt    <= settle_cnt_d;
      man_left_q    <= man_left;
      man_right_q   <= man_right;
      move_forward  <= fwd_d;
      move_backward <= bwd_d;
      semi_enable   <= semi_en_d;
      auto_enable   <= auto_en_d;
      switching     <= switching_d;
    end
  end

  always_comb begin
    state_d      = state;
    target_d     = target;
    active_d     = active_q;
    settle_cnt_d = settle_cnt;
    case (state)
      ST_IDLE: begin
        if (req_mode != MODE_OFF) begin
          target_d     = req_mode;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_ACTIVE: begin
        if (req_mode != active_q) begin
          state_d  = ST_DRAIN;
          active_d = MODE_OFF;
        end
      end
      ST_DRAIN: begin
        if (!is_turning) begin
          target_d     = req_mode;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // A changed request mid-settle restarts the full hold.
        if (req_mode != target) begin
          target_d     = req_mode;
          settle_cnt_d = '0;
        end else if (settle_cnt >= SETTLE_LAST) begin
          state_d  = (target == MODE_OFF) ? ST_IDLE : ST_ACTIVE;
          active_d = target;
        end else begin
          settle_cnt_d = settle_cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Source drives the car only while the grant is staying in place this cycle.
    stay_active = (state == ST_ACTIVE) && (state_d == ST_ACTIVE);
    fwd_d       = 1'b0;
    bwd_d       = 1'b0;
    turn_req    = 3'b000;
    if (stay_active) begin
      case (active_q)
        MODE_MANUAL: begin
          fwd_d    = man_fwd & ~man_bwd;
          bwd_d    = man_bwd & ~man_fwd;
          turn_req = {1'b0, man_left & ~man_left_q, man_right & ~man_right_q};
        end
        MODE_SEMI: begin
          fwd_d    = semi_fwd;
          turn_req = {semi_tb, semi_tl, semi_tr};
        end
        MODE_AUTO: begin
          fwd_d    = auto_fwd;
          turn_req = {auto_tb, auto_tl, auto_tr};
        end
        default: begin
          fwd_d    = 1'b0;
          turn_req = 3'b000;
        end
      endcase
    end
    if (gate_busy) turn_req = 3'b000;

    semi_en_d   = stay_active && (active_q == MODE_SEMI);
    auto_en_d   = stay_active && (active_q == MODE_AUTO);
    switching_d = (state_d == ST_DRAIN) || (state_d == ST_SETTLE);
  end

  turn_gate #(
    .TURN_GUARD (TURN_GUARD),
    .CNT_W      (CNT_W)
  ) u_turn_gate (
    .clk        (clk),
    .rst        (rst),
    .req        (turn_req),
    .is_turning (is_turning),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .turn_back  (turn_back),
    .busy       (gate_busy)
  );

endmodule

// File: doc/drive_mode_arbiter.md
Name: drive_mode_arbiter

Overview:
- Owns the car's single motion/turn command interface and grants it to one of three requesters: manual buttons, the semi-automatic controller, or the autonomous controller.
- Generates the enable for the semi/auto controllers and sequences safe mode changes: stop, wait for any turn to finish, settle, then hand over.
- Filters turn triggers so that only one turn is in flight at a time, with a guard gap after each turn.
- Sits between the mode switches and controllers upstream and the car motion model downstream. Runs on the 500 Hz system tick clock.

Parameters:
- SETTLE, 50, cycles the motors are held stopped before a new mode is granted (0.1 s at 500 Hz); minimum 1.
- TURN_GUARD, 10, cycles after is_turning falls before another turn trigger is accepted; minimum 1.

Ports:
- clk  in  1  system clock, 500 Hz
- rst  in  1  synchronous, active-high reset
- mode_req  in  2  requested mode: 0 OFF, 1 MANUAL, 2 SEMI, 3 AUTO
- is_turning  in  1  high while the car model executes a turn
- man_fwd, man_bwd, man_left, man_right  in  1 each  manual button levels
- semi_fwd, semi_tl, semi_tr, semi_tb  in  1 each  semi controller forward level and turn triggers
- auto_fwd, auto_tl, auto_tr, auto_tb  in  1 each  auto controller forward level and turn triggers
- move_forward, move_backward  out  1 each  motion levels to the car
- turn_left, turn_right, turn_back  out  1 each  one-cycle turn pulses to the car
- semi_enable, auto_enable  out  1 each  enables for the respective controllers
- active_mode  out  2  currently granted mode
- switching  out  1  high while a mode change is in progress

Behaviour:
- Reset (synchronous, active-high, clk): all outputs 0; state IDLE; all counters 0; active_mode = OFF. Reset mid-turn or mid-switch aborts immediately.
- States:
  - IDLE: outputs quiet. If mode_req != OFF, latch target = mode_req and go to SETTLE_S.
  - ACTIVE: the granted source drives the car. If mode_req != active_mode, go to DRAIN.
  - DRAIN: move_* = 0, no turn pulses, enables = 0, switching = 1. Stay until is_turning = 0, then latch target = mode_req, clear the settle counter, and go to SETTLE_S.
  - SETTLE_S: outputs stopped, switching = 1, count SETTLE cycles.
    - If mode_req changes during the count, re-latch target and restart the count.
    - At the end of the count: target OFF goes to IDLE; any other target goes to ACTIVE with active_mode = target.
- Enables: semi_enable = 1 only in ACTIVE with active_mode = SEMI; auto_enable likewise for AUTO. Registered, so they rise 1 cycle after ACTIVE is entered.
- Motion in ACTIVE:
  - MANUAL: move_forward = man_fwd & ~man_bwd; move_backward = man_bwd & ~man_fwd. Both pressed gives both 0.
  - SEMI/AUTO: move_forward = the granted source's fwd; move_backward = 0.
  - All motion outputs are registered, 1-cycle latency.
- Turn sources:
  - MANUAL: rising edges of man_left/man_right. Edge-detect registers update every cycle in every state, so a button held across a grant does not fire.
  - SEMI/AUTO: the granted source's tl/tr/tb, level-sampled.
- Turn acceptance: only in ACTIVE, with is_turning = 0, and guard counter = 0.
  - Priority: back > left > right. Exactly one pulse is issued, for one cycle; lower-priority requests that cycle are dropped.
  - After a pulse, further triggers are blocked until is_turning has risen and then fallen; the guard counter then loads TURN_GUARD and counts to 0.
  - If is_turning never rises within 4 cycles of the pulse, the block unblocks and loads the guard anyway.
- Turn pulses are never issued in IDLE, DRAIN, or SETTLE_S.
- Counters: width $clog2(max(SETTLE, TURN_GUARD) + 1); saturate, never wrap.

Decomposition:
- Shared package drive_pkg: mode encodings (MODE_OFF/MANUAL/SEMI/AUTO) and arbiter state encodings. The other car controllers reuse the mode encodings.
- One sub-module, turn_gate: priority select, pulse generation, the wait-for-turn-complete logic, and the guard counter. Inputs are the request vector and is_turning; outputs are the pulses and a busy flag.

Test Plan:
- Reset then mode_req=SEMI: switching=1 for 50 cycles; active_mode=2 on the next cycle; semi_enable=1 one cycle later; auto_enable stays 0.
- SEMI active, semi_tl and semi_tb high together: exactly one turn_back pulse. With is_turning high for 20 cycles and then low, a semi_tr arriving 5 cycles after the fall is ignored; one arriving 10 or more cycles after the fall produces a turn_right pulse.
- MANUAL active, man_fwd=man_bwd=1: both move outputs 0. Release man_bwd: move_forward=1 one cycle later.
- Switch SEMI->AUTO while is_turning=1: move_forward drops to 0 next cycle; DRAIN holds until is_turning=0; then 50 settle cycles; auto_enable=1; no turn pulses throughout.
- mode_req toggles AUTO->MANUAL at settle cycle 30: the count restarts and MANUAL is granted 50 cycles after the toggle. man_left held through the grant produces no pulse; the next fresh press produces one turn_left pulse.
- Assert rst during SETTLE_S and during a pending turn: next cycle all outputs 0, state IDLE, guard cleared.
